ucode_sequencer: RTL and testbench



---
 rtl/ucode_sequencer_if.sv | 42 ++++
 rtl/ucode_sequencer.sv | 152 +++++++++++++++
 tb/tb_ucode_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ucode_sequencer_if.sv
// Purpose    : bundle of the sequencer's opcode, ROM, micro-op and control/status signals.
// Latency    : n/a (wires only); slave = sequencer side, master = surrounding logic.
// Backpressure: op_valid/op_ready and uop_valid/uop_ready are valid-ready pairs.
// Ports:
//   op_valid/op_data/op_ready      opcode byte in from the fetch unit
//   rom_adr/rom_next               next-address ROM lookup (rom_next is combinational)
//   uop_valid/uop_adr/uop_ready    micro-address out to the ARM emitter
//   flush/clr_err                  abort current sequence / clear sticky error
//   busy/err/err_code              status
//   instr_cnt/uop_cnt              wrapping performance counters
interface ucode_sequencer_if #(
  parameter int ADR_W = 9,
  parameter int CNT_W = 16
);
  logic             op_valid;
  logic [7:0]       op_data;
  logic             op_ready;
  logic [ADR_W-1:0] rom_adr;
  logic [ADR_W-1:0] rom_next;
  logic             uop_valid;
  logic [ADR_W-1:0] uop_adr;
  logic             uop_ready;
  logic             flush;
  logic             clr_err;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] uop_cnt;

  modport slave (
    input  op_valid, op_data, rom_next, uop_ready, flush, clr_err,
    output op_ready, rom_adr, uop_valid, uop_adr, busy, err, err_code,
           instr_cnt, uop_cnt
  );

  modport master (
    output op_valid, op_data, rom_next, uop_ready, flush, clr_err,
    input  op_ready, rom_adr, uop_valid, uop_adr, busy, err, err_code,
           instr_cnt, uop_cnt
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Purpose    : walks the next-address ROM chain for one JVM opcode at a time.
// Latency    : first micro-address 1 cycle after opcode accept, then one per uop handshake.
// Backpressure: cur holds while uop_ready=0; op_ready=0 whenever a sequence or error is open.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   sq (slave)   opcode in, ROM lookup, micro-address out, flush/clr_err, status, counters
module ucode_sequencer #(
  parameter int ADR_W     = 9,
  parameter int LAST_ADR  = 320,
  parameter int MAX_STEPS = 16,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  ucode_sequencer_if.slave sq
);

  localparam int               STEP_W   = $clog2(MAX_STEPS + 1);
  localparam logic [ADR_W-1:0] LAST     = ADR_W'(LAST_ADR);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADR_W-1:0]  r_cur;
  logic [STEP_W-1:0] r_steps;
  logic              r_err;
  logic [1:0]        r_code;
  logic [CNT_W-1:0]  r_icnt;
  logic [CNT_W-1:0]  r_ucnt;

  state_t            w_state_nxt;
  logic [ADR_W-1:0]  w_cur_nxt;
  logic [STEP_W-1:0] w_steps_nxt;
  logic              w_err_nxt;
  logic [1:0]        w_code_nxt;
  logic [CNT_W-1:0]  w_icnt_nxt;
  logic [CNT_W-1:0]  w_ucnt_nxt;
  logic              w_op_ready;
  logic              w_uop_valid;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_steps <= '0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
      r_icnt  <= '0;
      r_ucnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_steps <= w_steps_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
      r_icnt  <= w_icnt_nxt;
      r_ucnt  <= w_ucnt_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_steps_nxt = r_steps;
    w_err_nxt   = r_err;
    w_code_nxt  = r_code;
    w_icnt_nxt  = r_icnt;
    w_ucnt_nxt  = r_ucnt;
    w_op_ready  = 1'b0;
    w_uop_valid = 1'b0;

    case (r_state)
      IDLE: begin
        // A flush in the same cycle wins, so do not advertise a handshake
        // that would be thrown away.
        w_op_ready = !sq.flush;
        if (sq.op_valid && !sq.flush) begin
          w_cur_nxt   = ADR_W'(sq.op_data);
          w_steps_nxt = STEP_W'(1);
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        w_uop_valid = 1'b1;
        if (sq.uop_ready && !sq.flush) begin
          w_ucnt_nxt = r_ucnt + CNT_W'(1);
          // End of chain is checked first, then illegal address over step limit.
          if (sq.rom_next == '0) begin
            w_icnt_nxt  = r_icnt + CNT_W'(1);
            w_steps_nxt = '0;
            w_state_nxt = IDLE;
          end else if (sq.rom_next > LAST) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'd1;
            w_state_nxt = ERROR;
          end else if (r_steps == STEP_MAX) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'd2;
            w_state_nxt = ERROR;
          end else begin
            w_cur_nxt   = sq.rom_next;
            w_steps_nxt = r_steps + STEP_W'(1);
          end
        end
      end

      ERROR: begin
        // cur keeps the faulting address for debug; clearing does not touch it.
        if (sq.clr_err) begin
          w_err_nxt   = 1'b0;
          w_code_nxt  = 2'd0;
          w_steps_nxt = '0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Flush overrides everything above, including the micro-op count.
    if (sq.flush) begin
      w_state_nxt = IDLE;
      w_steps_nxt = '0;
      w_err_nxt   = 1'b0;
      w_code_nxt  = 2'd0;
      w_ucnt_nxt  = r_ucnt;
      w_icnt_nxt  = r_icnt;
      w_cur_nxt   = r_cur;
    end
  end

  assign sq.op_ready  = w_op_ready;
  assign sq.uop_valid = w_uop_valid;
  assign sq.rom_adr   = r_cur;
  assign sq.uop_adr   = r_cur;
  assign sq.busy      = (r_state != IDLE);
  assign sq.err       = r_err;
  assign sq.err_code  = r_code;
  assign sq.instr_cnt = r_icnt;
  assign sq.uop_cnt   = r_ucnt;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Purpose    : directed, table-driven bench for ucode_sequencer with a stub next-address ROM.
// Latency    : inputs driven on the falling edge, outputs compared 1 ns later.
// Backpressure: uop_ready is driven per vector to exercise stalls.
module tb_ucode_sequencer;

  logic clk;
  logic rst;
  int   rom_mode;
  int   n_vec;
  int   n_bad;

  ucode_sequencer_if #(.ADR_W(9), .CNT_W(16)) bus ();

  ucode_sequencer #(
    .ADR_W(9), .LAST_ADR(320), .MAX_STEPS(16), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ROM: mode 0 holds the opcode chains, mode 1 loops adr+0x100 (9-bit wrap).
  always_comb begin
    bus.rom_next = 9'h000;
    if (rom_mode == 1) begin
      bus.rom_next = bus.rom_adr + 9'h100;
    end else begin
      case (bus.rom_adr)
        9'h059: bus.rom_next = 9'h100;
        9'h100: bus.rom_next = 9'h101;
        9'h08B: bus.rom_next = 9'h12C;
        9'h12C: bus.rom_next = 9'h12D;
        9'h05C: bus.rom_next = 9'h102;
        9'h102: bus.rom_next = 9'h103;
        9'h05A: bus.rom_next = 9'h1FF;
        default: bus.rom_next = 9'h000;
      endcase
    end
  end

  typedef struct {
    logic        ov;
    logic [7:0]  od;
    logic        ur;
    logic        fl;
    logic        ce;
    logic        e_ordy;
    logic        e_uv;
    logic [8:0]  e_adr;
    logic        e_busy;
    logic        e_err;
    logic [1:0]  e_code;
    logic [15:0] e_icnt;
    logic [15:0] e_ucnt;
  } vec_t;

  function automatic vec_t mk(input logic ov, input logic [7:0] od, input logic ur,
                              input logic fl, input logic ce, input logic ordy,
                              input logic uv, input logic [8:0] adr, input logic busy,
                              input logic err, input logic [1:0] code,
                              input int icnt, input int ucnt);
    vec_t v;
    v.ov = ov; v.od = od; v.ur = ur; v.fl = fl; v.ce = ce;
    v.e_ordy = ordy; v.e_uv = uv; v.e_adr = adr; v.e_busy = busy;
    v.e_err = err; v.e_code = code;
    v.e_icnt = 16'(icnt); v.e_ucnt = 16'(ucnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, ".op_ready"},  32'(bus.op_ready),  32'(v.e_ordy));
    chk({tag, ".uop_valid"}, 32'(bus.uop_valid), 32'(v.e_uv));
    chk({tag, ".uop_adr"},   32'(bus.uop_adr),   32'(v.e_adr));
    chk({tag, ".rom_adr"},   32'(bus.rom_adr),   32'(v.e_adr));
    chk({tag, ".busy"},      32'(bus.busy),      32'(v.e_busy));
    chk({tag, ".err"},       32'(bus.err),       32'(v.e_err));
    chk({tag, ".err_code"},  32'(bus.err_code),  32'(v.e_code));
    chk({tag, ".instr_cnt"}, 32'(bus.instr_cnt), 32'(v.e_icnt));
    chk({tag, ".uop_cnt"},   32'(bus.uop_cnt),   32'(v.e_ucnt));
  endtask

  // Drive inputs on the falling edge, compare the outputs for that cycle, and
  // let the following rising edge consume the inputs.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.op_valid  = v.ov;
    bus.op_data   = v.od;
    bus.uop_ready = v.ur;
    bus.flush     = v.fl;
    bus.clr_err   = v.ce;
    #1;
    check_out(v, tag);
  endtask

  vec_t tbl [11];
  vec_t v_rst;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rom_mode = 0;
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_data = 8'h00; bus.uop_ready = 1'b0;
    bus.flush = 1'b0; bus.clr_err = 1'b0;

    v_rst = mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h000, 0, 0, 2'd0, 0, 0);
    #12;
    check_out(v_rst, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal chains: 0x59 (3 uops), 0x00 (1 uop), 0x8B (3 uops).
    //              ov od     ur fl ce  rdy uv adr     bsy er cd  ic uc
    tbl[0]  = mk(1, 8'h59, 1, 0, 0,  1,  0, 9'h000, 0, 0, 2'd0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h059, 1, 0, 2'd0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h100, 1, 0, 2'd0, 0, 1);
    tbl[3]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h101, 1, 0, 2'd0, 0, 2);
    tbl[4]  = mk(1, 8'h00, 1, 0, 0,  1,  0, 9'h101, 0, 0, 2'd0, 1, 3);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h000, 1, 0, 2'd0, 1, 3);
    tbl[6]  = mk(1, 8'h8B, 1, 0, 0,  1,  0, 9'h000, 0, 0, 2'd0, 2, 4);
    tbl[7]  = mk(1, 8'h33, 1, 0, 0,  0,  1, 9'h08B, 1, 0, 2'd0, 2, 4);
    tbl[8]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h12C, 1, 0, 2'd0, 2, 5);
    tbl[9]  = mk(0, 8'h00, 1, 0, 0,  0,  1, 9'h12D, 1, 0, 2'd0, 2, 6);
    tbl[10] = mk(0, 8'h00, 0, 0, 0,  1,  0, 9'h12D, 0, 0, 2'd0, 3, 7);
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Backpressure on 0x5C: three stall cycles before each accept.
    apply(mk(1, 8'h5C, 0, 0, 0, 1, 0, 9'h12D, 0, 0, 2'd0, 3, 7), "bp_acc");
    for (int k = 0; k < 3; k++) begin
      logic [8:0] a;
      a = (k == 0) ? 9'h05C : ((k == 1) ? 9'h102 : 9'h103);
      for (int s = 0; s < 3; s++) begin
        apply(mk(0, 8'h00, 0, 0, 0, 0, 1, a, 1, 0, 2'd0, 3, 7 + k), $sformatf("bp_stall%0d_%0d", k, s));
      end
      apply(mk(0, 8'h00, 1, 0, 0, 0, 1, a, 1, 0, 2'd0, 3, 7 + k), $sformatf("bp_go%0d", k));
    end
    apply(mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h103, 0, 0, 2'd0, 4, 10), "bp_done");

    // Illegal next address (0x1FF) from 0x5A, opcode ignored in ERROR, then clr_err.
    apply(mk(1, 8'h5A, 0, 0, 0, 1, 0, 9'h103, 0, 0, 2'd0, 4, 10), "il_acc");
    apply(mk(0, 8'h00, 1, 0, 0, 0, 1, 9'h05A, 1, 0, 2'd0, 4, 10), "il_uop");
    apply(mk(1, 8'h59, 0, 0, 0, 0, 0, 9'h05A, 1, 1, 2'd1, 4, 11), "il_err");
    apply(mk(0, 8'h00, 0, 0, 1, 0, 0, 9'h05A, 1, 1, 2'd1, 4, 11), "il_clr");
    apply(mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h05A, 0, 0, 2'd0, 4, 11), "il_idle");

    // Step limit: looping ROM, exactly 16 uops accepted, then err_code 2.
    rom_mode = 1;
    apply(mk(1, 8'h10, 0, 0, 0, 1, 0, 9'h05A, 0, 0, 2'd0, 4, 11), "sl_acc");
    for (int k = 0; k < 16; k++) begin
      apply(mk(0, 8'h00, 1, 0, 0, 0, 1, (k % 2 == 1) ? 9'h110 : 9'h010, 1, 0, 2'd0, 4, 11 + k),
            $sformatf("sl_uop%0d", k));
    end
    apply(mk(0, 8'h00, 1, 0, 1, 0, 0, 9'h110, 1, 1, 2'd2, 4, 27), "sl_err");
    rom_mode = 0;
    apply(mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h110, 0, 0, 2'd0, 4, 27), "sl_idle");

    // Flush during the second micro-op of 0x59: that handshake is not counted.
    apply(mk(1, 8'h59, 0, 0, 0, 1, 0, 9'h110, 0, 0, 2'd0, 4, 27), "fl_acc");
    apply(mk(0, 8'h00, 1, 0, 0, 0, 1, 9'h059, 1, 0, 2'd0, 4, 27), "fl_uop1");
    apply(mk(0, 8'h00, 1, 1, 0, 0, 1, 9'h100, 1, 0, 2'd0, 4, 28), "fl_uop2");
    apply(mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h100, 0, 0, 2'd0, 4, 28), "fl_idle");

    // Asynchronous reset mid-sequence, away from any clock edge.
    apply(mk(1, 8'h59, 0, 0, 0, 1, 0, 9'h100, 0, 0, 2'd0, 4, 28), "ar_acc");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 9'h059, 1, 0, 2'd0, 4, 28), "ar_issue");
    #2;
    rst = 1'b1;
    #1;
    check_out(v_rst, "ar_reset");
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 8'h00, 0, 0, 0, 1, 0, 9'h000, 0, 0, 2'd0, 0, 0), "ar_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
